// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, small FIFO, LSB-first serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 139,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       uart_line_out,
  output logic       busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    head;
  logic          empty, full_n, push, pop, bit_end, next_idle, busy_n;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  // FIFO bookkeeping and next values of the registered status outputs
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    head      = mem[rd_ptr[AW-1:0]];
    bit_end   = (cnt == CW'(CLKS_PER_BIT - 1));
    push      = in_valid && in_ready;
    pop       = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
    wr_ptr_n  = wr_ptr + PW'(push);
    rd_ptr_n  = rd_ptr + PW'(pop);
    full_n    = (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]) && (wr_ptr_n[AW] != rd_ptr_n[AW]);
    next_idle = empty && ((state == IDLE) || ((state == STOP) && bit_end));
    busy_n    = !next_idle || (wr_ptr_n != rd_ptr_n);
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      in_ready <= !full_n;
      busy     <= busy_n;
    end
  end

  // Serialiser; the line register is loaded with the level of the state being entered
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      uart_line_out <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt           <= '0;
          uart_line_out <= 1'b1;
          if (pop) begin
            shift         <= head;
            uart_line_out <= 1'b0;
            state         <= START;
`ifdef UART_TX_PARITY_EN
            parity        <= ^head;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            cnt           <= '0;
            bit_idx       <= '0;
            uart_line_out <= shift[0];
            state         <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx       <= '0;
`ifdef UART_TX_PARITY_EN
              uart_line_out <= parity;
              state         <= PARITY;
`else
              uart_line_out <= 1'b1;
              state         <= STOP;
`endif
            end else begin
              bit_idx       <= bit_idx + 3'(1);
              shift         <= {1'b0, shift[7:1]};
              uart_line_out <= shift[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt           <= '0;
            uart_line_out <= 1'b1;
            state         <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (pop) begin
              shift         <= head;
              uart_line_out <= 1'b0;
              state         <= START;
`ifdef UART_TX_PARITY_EN
              parity        <= ^head;
`endif
            end else begin
              uart_line_out <= 1'b1;
              state         <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt           <= '0;
          uart_line_out <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomised scoreboard bench for uart_tx_buffered: a line-level receiver model checks every frame.
module tb_uart_tx_buffered;

  localparam int C     = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       CLK;
  logic       RST_N;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       uart_line_out;
  logic       busy;

  uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .uart_line_out(uart_line_out), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         start_cyc[$];
  int         starts = 0;
  int         rx_cnt = 0;

  task automatic check(input bit ok, input string nm, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [10:0] build_frame(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  // Receiver model: on a start edge, pop the expected byte and compare every cycle of the frame
  int          mon_pos = -1;
  int          mon_bad = 0;
  logic [7:0]  mon_byte;
  logic [10:0] mon_frame;
  always @(negedge CLK) begin
    if (!RST_N) begin
      mon_pos = -1;
    end else begin
      if (mon_pos < 0 && uart_line_out == 1'b0) begin
        mon_bad = 0;
        if (exp_q.size() == 0) begin
          mon_byte = 8'h00;
          mon_bad = 1;
        end else begin
          mon_byte = exp_q.pop_front();
        end
        mon_frame = build_frame(mon_byte);
        mon_pos = 0;
        start_cyc.push_back(cyc);
        starts++;
      end
      if (mon_pos >= 0) begin
        if (uart_line_out !== mon_frame[mon_pos / C]) mon_bad++;
        mon_pos++;
        if (mon_pos == FB * C) begin
          checks++;
          if (mon_bad != 0) begin
            errors++;
            $display("FAIL frame: byte 0x%02h had %0d bad line cycles, required 0", mon_byte, mon_bad);
          end
          rx_cnt++;
          mon_pos = -1;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 1000) begin
      @(negedge CLK);
      in_valid = 1'b1;
      in_data  = b;
      acc = in_ready;
      if (acc) exp_q.push_back(b);
      @(posedge CLK);
      n++;
    end
    #1 in_valid = 1'b0;
    if (!acc) check(1'b0, "push_timeout", n, 1000);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (busy && n < 5000);
    check(!busy, nm, n, 5000);
  endtask

  // Single byte from idle: line still high right after acceptance, low after the next edge, busy for FB*C+1 edges
  task automatic send_timed(input logic [7:0] b, input string nm);
    int k;
    push_byte(b);
    @(negedge CLK);
    check(uart_line_out == 1'b1 && busy == 1'b1, {nm, "_accept"}, {uart_line_out, busy}, 3);
    k = 0;
    while (busy && k < 200) begin
      @(negedge CLK);
      k++;
      if (k == 1) check(uart_line_out == 1'b0, {nm, "_start_low"}, uart_line_out, 0);
    end
    check(k == FB * C + 1, {nm, "_busy_len"}, k, FB * C + 1);
  endtask

  initial begin
    int acc, n, mism, gap_bad, s0, r0, exp_rdy;
    bit saw_low;

    RST_N = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge CLK);
    check(uart_line_out == 1'b1, "rst_line", uart_line_out, 1);
    check(in_ready == 1'b1, "rst_ready", in_ready, 1);
    check(busy == 1'b0, "rst_busy", busy, 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    send_timed(8'h55, "b55");
    send_timed(8'h07, "b07");
    send_timed(8'h03, "b03");
    check(rx_cnt == 3, "single_rx_count", rx_cnt, 3);

    // Burst 0x00..0x0F with in_valid held high; in_ready must track the model occupancy
    s0 = starts;
    r0 = rx_cnt;
    acc = 0;
    n = 0;
    mism = 0;
    saw_low = 1'b0;
    while (acc < 16 && n < 3000) begin
      @(negedge CLK);
      #1;
      exp_rdy = ((acc - (starts - s0)) < DEPTH) ? 1 : 0;
      if (in_ready !== exp_rdy[0]) mism++;
      if (!in_ready) saw_low = 1'b1;
      in_valid = 1'b1;
      in_data = 8'(acc);
      if (in_ready) begin
        exp_q.push_back(8'(acc));
        acc++;
      end
      @(posedge CLK);
      n++;
    end
    #1 in_valid = 1'b0;
    check(acc == 16, "burst_accepted", acc, 16);
    check(mism == 0, "burst_ready_track", mism, 0);
    check(saw_low, "burst_ready_dropped", saw_low, 1);
    wait_idle("burst_idle_timeout");
    check(rx_cnt - r0 == 16, "burst_rx_count", rx_cnt - r0, 16);
    gap_bad = 0;
    for (int i = s0 + 1; i < s0 + 16 && i < start_cyc.size(); i++)
      if (start_cyc[i] - start_cyc[i-1] != FB * C) gap_bad++;
    check(gap_bad == 0, "burst_back_to_back", gap_bad, 0);
    check(exp_q.size() == 0, "burst_queue_drained", exp_q.size(), 0);

    // Async reset during data bit 3 of 0xA3 (bit 3 is 0, so the line is low before reset)
    push_byte(8'hA3);
    repeat (19) @(negedge CLK);
    check(uart_line_out == 1'b0, "pre_reset_bit3", uart_line_out, 0);
    #1 RST_N = 1'b0;
    #1;
    check(uart_line_out == 1'b1, "async_rst_line", uart_line_out, 1);
    check(busy == 1'b0, "async_rst_busy", busy, 0);
    check(in_ready == 1'b1, "async_rst_ready", in_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    check(busy == 1'b0 && uart_line_out == 1'b1, "post_rst_quiet", {busy, uart_line_out}, 1);
    r0 = rx_cnt;
    send_timed(8'h3C, "b3C");
    check(rx_cnt - r0 == 1, "post_rst_rx", rx_cnt - r0, 1);

    // Random bytes with random gaps
    r0 = rx_cnt;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge CLK);
      push_byte(8'($urandom));
    end
    wait_idle("rand_idle_timeout");
    check(rx_cnt - r0 == 24, "rand_rx_count", rx_cnt - r0, 24);
    check(exp_q.size() == 0, "rand_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
